jtkcpu_fetch16: RTL and testbench
=================================

# jtkcpu_fetch16

16-bit operand fetch sequencer for the KCPU core. It sits directly upstream of the 16-bit ALU. It turns an addressing mode plus an effective address into two big-endian byte reads on the 8-bit data bus. The assembled word is presented as the ALU's second operand with a one-cycle `done` strobe, and the program counter is advanced for immediate operands.

## Interface
- No parameters.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cen` in 1: clock enable; all state advances only on `clk` edges with `cen`=1.
- `start` in 1: request a fetch; sampled only in IDLE or DONE.
- `mode` in 2: 0 IMM, 1 DIR, 2 EXT, 3 IDX.
- `pc_in` in 16: current PC, used by IMM.
- `dp` in 8: direct-page register, used by DIR.
- `ea_in` in 16: effective address; DIR uses `[7:0]`, EXT/IDX use all 16 bits.
- `bus_addr` out 16: read address.
- `bus_rd` out 1: read request, held until acknowledged.
- `bus_din` in 8: read data, valid with `bus_ack`.
- `bus_ack` in 1: read completes on this edge (`cen`=1).
- `opnd` out 16: fetched word, stable from `done` until the next fetch completes.
- `pc_out` out 16: PC after the fetch.
- `busy` out 1: high in RD_HI and RD_LO.
- `done` out 1: one-cycle pulse in DONE.
- `abort` in 1: present only with `JTKCPU_FETCH16_ABORT_EN`.

## Operation
- States: IDLE, RD_HI, RD_LO, DONE.
- IDLE or DONE, `start`=1: latch base address A and mode, then go to RD_HI.
  - IMM: A=`pc_in`.
  - DIR: A={`dp`,`ea_in[7:0]`}.
  - EXT and IDX: A=`ea_in`.
- IDLE or DONE, `start`=0: DONE returns to IDLE; IDLE stays.
- RD_HI: `bus_rd`=1, `bus_addr`=A. On `bus_ack`, latch `bus_din` into the high-byte register and go to RD_LO.
- RD_LO: `bus_rd`=1, `bus_addr`=A+1, computed mod 2^16 (0xFFFF wraps to 0x0000). On `bus_ack`, latch `bus_din` as the low byte and go to DONE.
- Entry to DONE, on the same edge:
  - `opnd` updates to {hi,lo}.
  - IMM: `pc_out`=`pc_in`+2 mod 2^16, using `pc_in` latched at start.
  - Other modes: `pc_out`=latched `pc_in` unchanged.
- Neither `opnd` nor `pc_out` changes at any other time.
- `start` in RD_HI or RD_LO is ignored; there is no queueing.
- `bus_ack` outside RD_HI/RD_LO is ignored.
- `bus_addr` holds its last value when `bus_rd`=0.

## Timing
- Reset values:
  - state IDLE.
  - `opnd`=0x0000, `pc_out`=0x0000, `bus_addr`=0x0000.
  - `bus_rd`=0, `busy`=0, `done`=0.
  - Internal byte and address registers are zero.
- Outputs are registered or decoded from the state only. There is no combinational path from `bus_din` or `bus_ack` to any output.
- Zero-wait latency, with `cen` tied high: `start` high at edge N.
  - RD_HI during N..N+1.
  - RD_LO during N+1..N+2.
  - `done`=1 in the cycle after edge N+2, with `opnd` valid in that cycle.
- Each cycle with `bus_ack`=0 adds one cycle.
- With `cen`=0, the state holds and `done` stays high until the next `cen` edge.
- Back-to-back: `start` in DONE enters RD_HI on the next edge. Sustained throughput is one word per 3 cycles.
- Reset asserted mid-fetch: immediate return to reset values, and the partial high byte is discarded.

## Configuration
- `JTKCPU_FETCH16_ABORT_EN` defined: adds the `abort` input.
  - `abort`=1 on a `cen` edge in RD_HI or RD_LO returns to IDLE.
  - `bus_rd` drops and `done` is not pulsed; `opnd` and `pc_out` keep their previous values.
  - `abort` has priority over `bus_ack` on the same edge.
  - `abort` in IDLE or DONE is ignored, and `start` is still honoured.
- Undefined: the port is absent and the FSM behaves as if `abort`=0.

## Structure
- `jtkcpu_pkg` holds:
  - mode constants (IMM/DIR/EXT/IDX);
  - the FSM state encoding;
  - CC bit-index constants shared with the ALUs.
- Sub-module `jtkcpu_fetch16_agen`: combinational base-address mux plus the +1/+2 wrap-around incrementers, instanced once.

## Test plan
- IMM, `pc_in`=0x1234, memory [0x1234]=0xAB, [0x1235]=0xCD, zero wait → `bus_addr` 0x1234 then 0x1235; `opnd`=0xABCD and `pc_out`=0x1236 with `done` 3 cycles after start.
- DIR, `dp`=0x12, `ea_in`=0xFF34, memory [0x1234]=0x80, [0x1235]=0x01 → `opnd`=0x8001, `pc_out` unchanged.
- EXT, `ea_in`=0xFFFF, memory [0xFFFF]=0x5A, [0x0000]=0xA5 → second `bus_addr`=0x0000, `opnd`=0x5AA5.
- `bus_ack` low 2 cycles on the high read, `cen` toggling every other cycle, `start` pulsed while busy → `done` delayed accordingly, exactly one fetch performed, `done` width equals one `cen` period.
- Back-to-back IMM from 0x2000 then EXT 0x3000 with `start` held in DONE → second `done` 3 cycles after the first, `opnd` updates only at each DONE entry.
- `rst_n` low during RD_LO → outputs return to reset values asynchronously. With the macro, `abort` during RD_HI → IDLE, no `done`, `opnd` unchanged.

Source files
------------

// File: rtl/jtkcpu_pkg.sv
// Shared KCPU definitions: addressing modes, fetch FSM encoding, CC bit positions.
package jtkcpu_pkg;

  localparam logic [1:0] MODE_IMM = 2'd0;
  localparam logic [1:0] MODE_DIR = 2'd1;
  localparam logic [1:0] MODE_EXT = 2'd2;
  localparam logic [1:0] MODE_IDX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_HI = 2'd1,
    ST_RD_LO = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // Condition-code bit positions, common to the ALUs
  localparam int CC_C = 0;
  localparam int CC_V = 1;
  localparam int CC_Z = 2;
  localparam int CC_N = 3;
  localparam int CC_I = 4;
  localparam int CC_H = 5;
  localparam int CC_F = 6;
  localparam int CC_E = 7;

endpackage

// File: rtl/jtkcpu_fetch16_agen.sv
// Operand address generation: base-address mux per mode plus the A+1 and PC+2
// incrementers, both wrapping modulo 2^16.
module jtkcpu_fetch16_agen
  import jtkcpu_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [15:0] pc_in,
  input  logic [7:0]  dp,
  input  logic [15:0] ea_in,
  input  logic [15:0] base_q,
  input  logic [15:0] pc_q,
  output logic [15:0] base_addr,
  output logic [15:0] base_p1,
  output logic [15:0] pc_p2
);

  always_comb begin
    base_addr = ea_in;
    case (mode)
      MODE_IMM: base_addr = pc_in;
      MODE_DIR: base_addr = {dp, ea_in[7:0]};
      MODE_EXT: base_addr = ea_in;
      MODE_IDX: base_addr = ea_in;
      default:  base_addr = ea_in;
    endcase
  end

  assign base_p1 = base_q + 16'd1;
  assign pc_p2   = pc_q + 16'd2;

endmodule

// File: rtl/jtkcpu_fetch16.sv
// 16-bit big-endian operand fetch over the 8-bit bus, feeding the ALU operand B.
// Optional abort input enabled by defining JTKCPU_FETCH16_ABORT_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RD_HI | reading high byte at A
// ST_RD_LO | reading low byte at A+1
// ST_DONE  | opnd/pc_out valid, done pulsed; start here chains the next fetch
module jtkcpu_fetch16
  import jtkcpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [15:0] pc_in,
  input  logic [7:0]  dp,
  input  logic [15:0] ea_in,
  input  logic [7:0]  bus_din,
  input  logic        bus_ack,
`ifdef JTKCPU_FETCH16_ABORT_EN
  input  logic        abort,
`endif
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic [15:0] opnd,
  output logic [15:0] pc_out,
  output logic        busy,
  output logic        done
);

  fetch_state_e state_q, state_d;
  logic [1:0]   mode_q, mode_d;
  logic [15:0]  base_q, base_d;
  logic [15:0]  pc_q, pc_d;
  logic [7:0]   hi_q, hi_d;
  logic [15:0]  opnd_q, opnd_d;
  logic [15:0]  pc_out_q, pc_out_d;
  logic [15:0]  bus_addr_q, bus_addr_d;

  logic [15:0]  base_addr, base_p1, pc_p2;
  logic         abort_w;

`ifdef JTKCPU_FETCH16_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  jtkcpu_fetch16_agen u_agen (
    .mode      (mode),
    .pc_in     (pc_in),
    .dp        (dp),
    .ea_in     (ea_in),
    .base_q    (base_q),
    .pc_q      (pc_q),
    .base_addr (base_addr),
    .base_p1   (base_p1),
    .pc_p2     (pc_p2)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    base_d     = base_q;
    pc_d       = pc_q;
    hi_d       = hi_q;
    opnd_d     = opnd_q;
    pc_out_d   = pc_out_q;
    bus_addr_d = bus_addr_q;
    if (cen) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d    = ST_RD_HI;
            mode_d     = mode;
            base_d     = base_addr;
            pc_d       = pc_in;
            bus_addr_d = base_addr;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RD_HI: begin
          if (abort_w) begin
            state_d = ST_IDLE;
          end else if (bus_ack) begin
            hi_d       = bus_din;
            bus_addr_d = base_p1;
            state_d    = ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          if (abort_w) begin
            state_d = ST_IDLE;
          end else if (bus_ack) begin
            // opnd and pc_out move together, only on entry to DONE
            opnd_d   = {hi_q, bus_din};
            pc_out_d = (mode_q == MODE_IMM) ? pc_p2 : pc_q;
            state_d  = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_IMM;
      base_q     <= 16'h0000;
      pc_q       <= 16'h0000;
      hi_q       <= 8'h00;
      opnd_q     <= 16'h0000;
      pc_out_q   <= 16'h0000;
      bus_addr_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      base_q     <= base_d;
      pc_q       <= pc_d;
      hi_q       <= hi_d;
      opnd_q     <= opnd_d;
      pc_out_q   <= pc_out_d;
      bus_addr_q <= bus_addr_d;
    end
  end

  assign busy     = (state_q == ST_RD_HI) || (state_q == ST_RD_LO);
  assign bus_rd   = busy;
  assign done     = (state_q == ST_DONE);
  assign bus_addr = bus_addr_q;
  assign opnd     = opnd_q;
  assign pc_out   = pc_out_q;

endmodule

// File: tb/tb_jtkcpu_fetch16.sv
// Scoreboard bench for jtkcpu_fetch16: a memory responder checks read addresses,
// a done monitor checks opnd/pc_out against values queued at start.
module tb_jtkcpu_fetch16;
  import jtkcpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] pc_in = 16'h0000;
  logic [7:0]  dp = 8'h00;
  logic [15:0] ea_in = 16'h0000;
  logic [7:0]  bus_din = 8'h00;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic [15:0] opnd;
  logic [15:0] pc_out;
  logic        busy;
  logic        done;
`ifdef JTKCPU_FETCH16_ABORT_EN
  logic        abort = 1'b0;
`endif

  jtkcpu_fetch16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .start    (start),
    .mode     (mode),
    .pc_in    (pc_in),
    .dp       (dp),
    .ea_in    (ea_in),
    .bus_din  (bus_din),
    .bus_ack  (bus_ack),
`ifdef JTKCPU_FETCH16_ABORT_EN
    .abort    (abort),
`endif
    .bus_addr (bus_addr),
    .bus_rd   (bus_rd),
    .opnd     (opnd),
    .pc_out   (pc_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] opnd;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  logic [7:0]  mem [logic [15:0]];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall = 0;
  bit cen_toggle = 1'b0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int cur_w = 0;
  int last_w = 0;
  logic done_prev = 1'b0;
  exp_t mon_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder; also owns cen so it knows whether an ack gets consumed
  always @(negedge clk) begin
    logic cen_n;
    cen_n   = cen_toggle ? ~cen : 1'b1;
    cen     = cen_n;
    bus_ack = 1'b0;
    if (bus_rd && rst_n) begin
      if (stall > 0) begin
        if (cen_n) stall--;
      end else begin
        bus_ack = 1'b1;
        bus_din = mem_rd(bus_addr);
        if (cen_n) begin
          if (addr_q.size() == 0) check_eq("addr_unexpected", 32'(addr_q.size()), 32'd1);
          else check_eq("bus_addr", 32'(bus_addr), 32'(addr_q.pop_front()));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
      cur_w = 0;
    end else begin
      if (done && !done_prev) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) check_eq("done_unexpected", 32'(exp_q.size()), 32'd1);
        else begin
          mon_e = exp_q.pop_front();
          check_eq("sb_opnd", 32'(opnd), 32'(mon_e.opnd));
          check_eq("sb_pc_out", 32'(pc_out), 32'(mon_e.pc));
        end
      end
      if (done) cur_w++;
      else if (done_prev) begin
        last_w = cur_w;
        cur_w = 0;
      end
      done_prev = done;
    end
  end

  task automatic drive(input logic [1:0] m, input logic [15:0] pc, input logic [7:0] d,
                       input logic [15:0] ea);
    mode = m; pc_in = pc; dp = d; ea_in = ea;
  endtask

  task automatic push_exp(input logic [1:0] m, input logic [15:0] pc, input logic [7:0] d,
                          input logic [15:0] ea);
    logic [15:0] a, a1;
    exp_t e;
    a  = (m == MODE_IMM) ? pc : (m == MODE_DIR) ? {d, ea[7:0]} : ea;
    a1 = a + 16'd1;
    addr_q.push_back(a);
    addr_q.push_back(a1);
    e.opnd = {mem_rd(a), mem_rd(a1)};
    e.pc   = (m == MODE_IMM) ? pc + 16'd2 : pc;
    exp_q.push_back(e);
  endtask

  // Returns just after the accepting edge (hold=1) or at the following negedge with start low
  task automatic issue(input logic [1:0] m, input logic [15:0] pc, input logic [7:0] d,
                       input logic [15:0] ea, input bit hold);
    @(negedge clk);
    drive(m, pc, d, ea);
    push_exp(m, pc, d, ea);
    start = 1'b1;
    do @(posedge clk); while (!cen);
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input int limit, output int lat);
    int c0;
    c0 = done_cnt;
    lat = 0;
    while (done_cnt == c0 && lat < limit) begin
      @(posedge clk);
      lat++;
    end
    if (done_cnt == c0) check_eq("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int lat, c0, d1;
    logic [15:0] opnd_b, pc_b;

    #12;
    check_eq("rst_opnd", 32'(opnd), 32'h0);
    check_eq("rst_pc_out", 32'(pc_out), 32'h0);
    check_eq("rst_bus_addr", 32'(bus_addr), 32'h0);
    check_eq("rst_bus_rd", 32'(bus_rd), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // IMM, zero wait
    mem[16'h1234] = 8'hAB; mem[16'h1235] = 8'hCD;
    issue(MODE_IMM, 16'h1234, 8'h00, 16'h0000, 1'b0);
    wait_done(50, lat);
    check_eq("imm_latency", 32'(lat), 32'd3);
    check_eq("imm_opnd", 32'(opnd), 32'hABCD);
    check_eq("imm_pc_out", 32'(pc_out), 32'h1236);
    repeat (3) @(negedge clk);
    check_eq("imm_done_width", 32'(last_w), 32'd1);
    check_eq("imm_idle_busy", 32'(busy), 32'd0);

    // DIR: high ea byte must be ignored
    mem[16'h1234] = 8'h80; mem[16'h1235] = 8'h01;
    issue(MODE_DIR, 16'h4321, 8'h12, 16'hFF34, 1'b0);
    wait_done(50, lat);
    check_eq("dir_opnd", 32'(opnd), 32'h8001);
    check_eq("dir_pc_out", 32'(pc_out), 32'h4321);

    // EXT wrap of the second address
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hA5;
    issue(MODE_EXT, 16'h0100, 8'h00, 16'hFFFF, 1'b0);
    wait_done(50, lat);
    check_eq("ext_opnd", 32'(opnd), 32'h5AA5);
    check_eq("ext_pc_out", 32'(pc_out), 32'h0100);

    // Stalled high read, cen every other cycle, start pulsed while busy
    cen_toggle = 1'b1;
    stall = 2;
    c0 = done_cnt;
    issue(MODE_IDX, 16'h0200, 8'h00, 16'h0C00, 1'b0);
    lat = 0;
    while (done_cnt == c0 && lat < 200) begin
      @(posedge clk);
      lat++;
      #1 start = busy;
    end
    start = 1'b0;
    check_eq("stall_delayed", 32'(lat > 3), 32'd1);
    repeat (12) @(negedge clk);
    check_eq("stall_one_fetch", 32'(done_cnt - c0), 32'd1);
    check_eq("stall_done_width", 32'(last_w), 32'd2);
    check_eq("stall_idle_busy", 32'(busy), 32'd0);
    cen_toggle = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back IMM then EXT with start held through DONE
    issue(MODE_IMM, 16'h2000, 8'h00, 16'h0000, 1'b1);
    @(negedge clk);
    drive(MODE_EXT, 16'h2000, 8'h00, 16'h3000);
    push_exp(MODE_EXT, 16'h2000, 8'h00, 16'h3000);
    wait_done(50, lat);
    d1 = last_done_cyc;
    opnd_b = {mem_rd(16'h2000), mem_rd(16'h2001)};
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b_busy", 32'(busy), 32'd1);
    check_eq("b2b_opnd_hold", 32'(opnd), 32'(opnd_b));
    check_eq("b2b_pc_hold", 32'(pc_out), 32'h2002);
    wait_done(50, lat);
    check_eq("b2b_gap", 32'(last_done_cyc - d1), 32'd3);
    repeat (2) @(negedge clk);

    // Reset asserted in RD_LO
    issue(MODE_EXT, 16'h4444, 8'h00, 16'h5000, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst2_opnd", 32'(opnd), 32'h0);
    check_eq("rst2_pc_out", 32'(pc_out), 32'h0);
    check_eq("rst2_bus_addr", 32'(bus_addr), 32'h0);
    check_eq("rst2_bus_rd", 32'(bus_rd), 32'h0);
    check_eq("rst2_busy", 32'(busy), 32'h0);
    check_eq("rst2_done", 32'(done), 32'h0);
    addr_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // IDX after reset
    mem[16'h1234] = 8'h3C; mem[16'h1235] = 8'hC3;
    issue(MODE_IDX, 16'h0777, 8'hEE, 16'h1234, 1'b0);
    wait_done(50, lat);
    check_eq("idx_opnd", 32'(opnd), 32'h3CC3);
    check_eq("idx_pc_out", 32'(pc_out), 32'h0777);

`ifdef JTKCPU_FETCH16_ABORT_EN
    opnd_b = opnd;
    pc_b = pc_out;
    c0 = done_cnt;
    stall = 10;
    issue(MODE_IMM, 16'h6000, 8'h00, 16'h0000, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_bus_rd", 32'(bus_rd), 32'd0);
    repeat (6) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt - c0), 32'd0);
    check_eq("abort_opnd", 32'(opnd), 32'(opnd_b));
    check_eq("abort_pc_out", 32'(pc_out), 32'(pc_b));
    addr_q.delete();
    exp_q.delete();
    stall = 0;
`endif

    repeat (4) @(negedge clk);
    check_eq("sb_exp_empty", 32'(exp_q.size()), 32'd0);
    check_eq("sb_addr_empty", 32'(addr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule
